// File: rtl/reg_writeback_queue_if.sv
// Write-request, register-file writeback and forwarding-lookup signals of reg_writeback_queue.
// master = producer / register-file side, slave = the queue itself.
interface reg_writeback_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          REQ_VALID;
    logic          REQ_READY;
    logic [AW-1:0] REQ_ADDRESS;
    logic [DW-1:0] REQ_DATA;
    logic          HOLD;
    logic [DW-1:0] WB_IN;
    logic [AW-1:0] WB_INADDRESS;
    logic          WB_WRITE;
    logic [AW-1:0] FWD1ADDRESS;
    logic          FWD1HIT;
    logic [DW-1:0] FWD1DATA;
    logic [AW-1:0] FWD2ADDRESS;
    logic          FWD2HIT;
    logic [DW-1:0] FWD2DATA;
    logic [CW-1:0] PENDING;

    modport master (
        output REQ_VALID, REQ_ADDRESS, REQ_DATA, HOLD, FWD1ADDRESS, FWD2ADDRESS,
        input  REQ_READY, WB_IN, WB_INADDRESS, WB_WRITE,
               FWD1HIT, FWD1DATA, FWD2HIT, FWD2DATA, PENDING
    );

    modport slave (
        input  REQ_VALID, REQ_ADDRESS, REQ_DATA, HOLD, FWD1ADDRESS, FWD2ADDRESS,
        output REQ_READY, WB_IN, WB_INADDRESS, WB_WRITE,
               FWD1HIT, FWD1DATA, FWD2HIT, FWD2DATA, PENDING
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Register-file write queue: FIFO of (address, data) drained one per cycle, with two forwarding lookups.
// Optional macro WB_COALESCE_EN: a push matching a queued non-head entry overwrites it in place.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    reg_writeback_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_mem_addr [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_wb_in;
    logic [AW-1:0] r_wb_addr;
    logic          r_wb_write;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_alloc;
    logic             w_coal_hit;
    logic [PW-1:0]    w_coal_idx;
    logic [PW-1:0]    w_wr_idx;
    logic [PW-1:0]    w_idx [DEPTH];
    logic [DEPTH-1:0] w_live;

    genvar gi;

    // Slot gi is the gi-th oldest queued entry; index arithmetic wraps modulo DEPTH.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign w_idx[gi]  = r_rd_ptr + PW'(gi);
            assign w_live[gi] = (CW'(gi) < r_count);
        end
    endgenerate

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = bus.REQ_VALID & ~w_full;
    assign w_pop   = (r_count != '0) & ~bus.HOLD;
    assign w_alloc = w_push & ~w_coal_hit;

`ifdef WB_COALESCE_EN
    // The head is skipped so a value already on its way out is never changed.
    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (w_live[i] && (r_mem_addr[w_idx[i]] == bus.REQ_ADDRESS)) begin
                w_coal_hit = 1'b1;
                w_coal_idx = w_idx[i];
            end
        end
    end
`else
    assign w_coal_hit = 1'b0;
    assign w_coal_idx = '0;
`endif

    assign w_wr_idx = w_coal_hit ? w_coal_idx : r_wr_ptr;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_wb_in    <= '0;
            r_wb_addr  <= '0;
            r_wb_write <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PW'(1);
                r_wb_in   <= r_mem_data[r_rd_ptr];
                r_wb_addr <= r_mem_addr[r_rd_ptr];
            end
            r_wb_write <= w_pop;
            r_count    <= r_count + CW'(w_alloc) - CW'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && w_push) begin
            r_mem_addr[w_wr_idx] <= bus.REQ_ADDRESS;
            r_mem_data[w_wr_idx] <= bus.REQ_DATA;
        end
    end

    // Later matches override earlier ones: WB register lowest, newest queued entry highest.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [AW-1:0] w_addr;
            logic          w_hit;
            logic [DW-1:0] w_data;

            assign w_addr = (gi == 0) ? bus.FWD1ADDRESS : bus.FWD2ADDRESS;

            always_comb begin
                w_hit  = 1'b0;
                w_data = '0;
                if (r_wb_write && (r_wb_addr == w_addr)) begin
                    w_hit  = 1'b1;
                    w_data = r_wb_in;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_live[i] && (r_mem_addr[w_idx[i]] == w_addr)) begin
                        w_hit  = 1'b1;
                        w_data = r_mem_data[w_idx[i]];
                    end
                end
            end
        end
    endgenerate

    assign bus.REQ_READY    = ~w_full;
    assign bus.PENDING      = r_count;
    assign bus.WB_IN        = r_wb_in;
    assign bus.WB_INADDRESS = r_wb_addr;
    assign bus.WB_WRITE     = r_wb_write;
    assign bus.FWD1HIT      = g_fwd[0].w_hit;
    assign bus.FWD1DATA     = g_fwd[0].w_data;
    assign bus.FWD2HIT      = g_fwd[1].w_hit;
    assign bus.FWD2DATA     = g_fwd[1].w_data;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int DW    = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    reg_writeback_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes in arrival order plus the presented WB entry.
    ent_t          mq[$];
    logic          m_wb_write = 1'b0;
    logic [AW-1:0] m_wb_addr  = '0;
    logic [DW-1:0] m_wb_data  = '0;
    bit            armed      = 1'b0;

    always @(posedge CLK) begin
        if (!RESET) begin
            mq.delete();
            m_wb_write = 1'b0;
            m_wb_addr  = '0;
            m_wb_data  = '0;
            armed      = 1'b1;
        end else begin
            bit   push;
            bit   pop;
            int   hit;
            ent_t e;
            push = bus.REQ_VALID && (mq.size() < DEPTH);
            pop  = (mq.size() > 0) && !bus.HOLD;
            m_wb_write = pop;
            if (pop) begin
                m_wb_addr = mq[0].a;
                m_wb_data = mq[0].d;
                void'(mq.pop_front());
                $display("WB  R%0d <= 0x%02h  (pending %0d)", m_wb_addr, m_wb_data, mq.size());
            end
            if (push) begin
                hit = -1;
`ifdef WB_COALESCE_EN
                begin
                    int lo;
                    lo = pop ? 0 : 1;
                    for (int i = mq.size() - 1; i >= lo && hit < 0; i--)
                        if (mq[i].a == bus.REQ_ADDRESS) hit = i;
                end
`endif
                if (hit >= 0) begin
                    mq[hit].d = bus.REQ_DATA;
                end else begin
                    e.a = bus.REQ_ADDRESS;
                    e.d = bus.REQ_DATA;
                    mq.push_back(e);
                end
                $display("REQ R%0d <= 0x%02h  (%s)", bus.REQ_ADDRESS, bus.REQ_DATA,
                         (hit >= 0) ? "merged" : "queued");
            end
        end
    end

    function automatic void m_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (m_wb_write && m_wb_addr == a) begin
            hit = 1'b1;
            d   = m_wb_data;
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].a == a) begin
                hit = 1'b1;
                d   = mq[i].d;
            end
        end
    endfunction

    always @(negedge CLK) begin
        if (armed) begin
            logic          h;
            logic [DW-1:0] d;
            check("mdl_ready",    bus.REQ_READY,    mq.size() < DEPTH);
            check("mdl_pending",  bus.PENDING,      mq.size());
            check("mdl_wb_write", bus.WB_WRITE,     m_wb_write);
            check("mdl_wb_addr",  bus.WB_INADDRESS, m_wb_addr);
            check("mdl_wb_in",    bus.WB_IN,        m_wb_data);
            m_fwd(bus.FWD1ADDRESS, h, d);
            check("mdl_fwd1hit",  bus.FWD1HIT,  h);
            check("mdl_fwd1data", bus.FWD1DATA, d);
            m_fwd(bus.FWD2ADDRESS, h, d);
            check("mdl_fwd2hit",  bus.FWD2HIT,  h);
            check("mdl_fwd2data", bus.FWD2DATA, d);
        end
    end

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.REQ_VALID   = 1'b1;
        bus.REQ_ADDRESS = a;
        bus.REQ_DATA    = d;
        tick();
        bus.REQ_VALID   = 1'b0;
    endtask

    task automatic expect_wb(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({name, "_write"}, bus.WB_WRITE, 1'b1);
        check({name, "_addr"},  bus.WB_INADDRESS, a);
        check({name, "_in"},    bus.WB_IN, d);
    endtask

    initial begin
        bus.REQ_VALID   = 1'b0;
        bus.REQ_ADDRESS = '0;
        bus.REQ_DATA    = '0;
        bus.HOLD        = 1'b0;
        bus.FWD1ADDRESS = '0;
        bus.FWD2ADDRESS = '0;

        tick();
        tick();
        RESET = 1'b1;
        check("rst_wb_write", bus.WB_WRITE, 1'b0);
        check("rst_wb_in",    bus.WB_IN, 8'h00);
        check("rst_pending",  bus.PENDING, 3'd0);
        check("rst_ready",    bus.REQ_READY, 1'b1);

        // Single-request latency.
        push(3'd3, 8'h5A);
        check("lat_pending_k",  bus.PENDING, 3'd1);
        check("lat_write_k",    bus.WB_WRITE, 1'b0);
        tick();
        expect_wb("lat_k1", 3'd3, 8'h5A);
        tick();
        check("lat_write_k2",   bus.WB_WRITE, 1'b0);

        // Fill under HOLD and look up pending values.
        bus.HOLD = 1'b1;
        push(3'd1, 8'h11);
        push(3'd2, 8'h22);
        push(3'd1, 8'h33);
        push(3'd4, 8'h44);
        check("full_pending", bus.PENDING, 3'd4);
        check("full_ready",   bus.REQ_READY, 1'b0);
        bus.FWD1ADDRESS = 3'd1;
        bus.FWD2ADDRESS = 3'd7;
        #1;
        check("fwd1_hit",  bus.FWD1HIT, 1'b1);
        check("fwd1_data", bus.FWD1DATA, 8'h33);
        check("fwd2_hit",  bus.FWD2HIT, 1'b0);
        check("fwd2_data", bus.FWD2DATA, 8'h00);
        push(3'd7, 8'h77);
        check("full_drop_pending", bus.PENDING, 3'd4);
        check("hold_no_write",     bus.WB_WRITE, 1'b0);

        // Release HOLD: in-order drain.
        bus.HOLD = 1'b0;
        tick();
        expect_wb("drain0", 3'd1, 8'h11);
        check("drain0_ready",   bus.REQ_READY, 1'b1);
        check("drain0_pending", bus.PENDING, 3'd3);
        tick();
        expect_wb("drain1", 3'd2, 8'h22);
        tick();
        expect_wb("drain2", 3'd1, 8'h33);
        tick();
        expect_wb("drain3", 3'd4, 8'h44);
        tick();
        check("drain_idle", bus.WB_WRITE, 1'b0);

        // Steady push+pop at PENDING=2; pointers wrap several times.
        bus.HOLD = 1'b1;
        push(3'd0, 8'hA0);
        push(3'd1, 8'hA1);
        bus.HOLD = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] exp_d;
            logic [AW-1:0] exp_a;
            push(AW'((i + 2) % 8), DW'(8'hB0 + i));
            exp_a = AW'(i % 8);
            exp_d = (i < 2) ? DW'(8'hA0 + i) : DW'(8'hB0 + i - 2);
            check("stream_pending", bus.PENDING, 3'd2);
            expect_wb("stream", exp_a, exp_d);
        end

        // Reset in the middle of activity.
        bus.HOLD = 1'b1;
        push(3'd5, 8'hC5);
        push(3'd6, 8'hC6);
        bus.HOLD = 1'b0;
        tick();
        check("pre_rst_pending", bus.PENDING, 3'd3);
        check("pre_rst_write",   bus.WB_WRITE, 1'b1);
        bus.FWD1ADDRESS = 3'd5;
        bus.FWD2ADDRESS = 3'd2;
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        check("mid_rst_write",   bus.WB_WRITE, 1'b0);
        check("mid_rst_pending", bus.PENDING, 3'd0);
        check("mid_rst_fwd1hit", bus.FWD1HIT, 1'b0);
        check("mid_rst_fwd2hit", bus.FWD2HIT, 1'b0);

        // Same-address requests: merged when coalescing, separate otherwise.
        bus.HOLD        = 1'b1;
        bus.FWD1ADDRESS = 3'd6;
        push(3'd5, 8'h01);
        push(3'd6, 8'h02);
        push(3'd6, 8'h03);
        bus.HOLD = 1'b0;
`ifdef WB_COALESCE_EN
        check("coal_pending", bus.PENDING, 3'd2);
        tick();
        expect_wb("coal0", 3'd5, 8'h01);
        tick();
        expect_wb("coal1", 3'd6, 8'h03);
`else
        check("nocoal_pending", bus.PENDING, 3'd3);
        tick();
        expect_wb("nocoal0", 3'd5, 8'h01);
        tick();
        expect_wb("nocoal1", 3'd6, 8'h02);
        tick();
        expect_wb("nocoal2", 3'd6, 8'h03);
`endif
        check("last_fwd1_data", bus.FWD1DATA, 8'h03);
        tick();
        check("end_idle", bus.WB_WRITE, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
